// File: rtl/tactile_rd_demod_pkg.sv
// Shared definitions for the tactile read-wire demodulator slice.
// Holds the emitter state encoding, the accumulator width rule and the
// channel-tag width rule used by tactile_rd_demod and tactile_acc_bank.
// Configuration macro honoured by the slice: TACTILE_RD_MIDSCALE_EN.
package tactile_pkg;

  // Emitter states: idle, or presenting one bank entry per channel.
  typedef enum logic {
    E_IDLE = 1'b0,
    E_SHOW = 1'b1
  } emit_state_e;

  // Default number of read wires on the sensing array.
  localparam int TACTILE_RD_WIRE_CNT_DEF = 2;

  // Channel-tag width: at least one bit so the tag port always exists.
  function automatic int tactile_ch_w(input int wires);
    return (wires > 1) ? $clog2(wires) : 1;
  endfunction

  // Channel-tag width for the default array size.
  localparam int TACTILE_CH_W = tactile_ch_w(TACTILE_RD_WIRE_CNT_DEF);

  // Accumulator width: sample bits, one sign bit, one guard bit, plus
  // enough bits to hold a full window of worst-case samples.
  function automatic int tactile_acc_w(input int adc_w, input int samples);
    return adc_w + 2 + $clog2(samples);
  endfunction

endpackage

// File: rtl/tactile_rd_demod_acc_bank.sv
// Bank of per-channel signed accumulators for the read-wire demodulator.
// Each accepted sample is added or subtracted depending on the excitation
// phase of its wire; snap_o shows every accumulator with the current
// sample already folded in, so the parent can capture a complete window.
module tactile_acc_bank
  import tactile_pkg::*;
#(
  parameter int RD_WIRE_CNT = 2,
  parameter int ACC_W       = 16,
  parameter int CH_W        = 1
) (
  input  logic                                clk_ref,
  input  logic                                rst_n,
  input  logic                                add_i,
  input  logic [CH_W-1:0]                     ch_i,
  input  logic signed [ACC_W-1:0]             x_i,
  input  logic [RD_WIRE_CNT-1:0]              phase_i,
  input  logic                                clr_i,
  output logic [RD_WIRE_CNT-1:0][ACC_W-1:0]   snap_o
);

  logic [RD_WIRE_CNT-1:0][ACC_W-1:0] acc_q;

  // Fold the current sample into its channel: add on high phase, subtract on low.
  always_comb begin
    snap_o = acc_q;
    for (int i = 0; i < RD_WIRE_CNT; i++) begin
      if (add_i && (ch_i == CH_W'(i))) begin
        if (phase_i[i]) begin
          snap_o[i] = acc_q[i] + x_i;
        end else begin
          snap_o[i] = acc_q[i] - x_i;
        end
      end
    end
  end

  // Accumulators restart from zero on clear (window end or disabled), else integrate.
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= snap_o;
    end
  end

endmodule

// File: rtl/tactile_rd_demod.sv
// Synchronous demodulator for the tactile array read wires.
// Tagged ADC samples are integrated per wire against the excitation phase
// over SAMPLES_PER_WIN scan rounds; each completed window is captured into
// a bank and streamed out one channel at a time over valid/ready.
// A window that completes while the previous bank is still being streamed
// is dropped and flagged in the sticky overrun output.
// Macro TACTILE_RD_MIDSCALE_EN: treat samples as offset-binary and remove
// the mid-scale offset before demodulation (DC-free); otherwise samples
// are zero-extended unsigned values.
module tactile_rd_demod
  import tactile_pkg::*;
#(
  parameter int RD_WIRE_CNT     = 2,
  parameter int ADC_W           = 12,
  parameter int SAMPLES_PER_WIN = 256,
  localparam int ACC_W          = tactile_acc_w(ADC_W, SAMPLES_PER_WIN),
  localparam int CH_W           = tactile_ch_w(RD_WIRE_CNT)
) (
  input  logic                    clk_ref,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [RD_WIRE_CNT-1:0]  exc_phase,
  input  logic                    adc_valid,
  input  logic [CH_W-1:0]         adc_ch,
  input  logic [ADC_W-1:0]        adc_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CH_W-1:0]         out_ch,
  output logic [ACC_W-1:0]        out_data,
  output logic                    overrun,
  input  logic                    clr_ovr,
  output logic                    busy
);

  localparam int RND_W = $clog2(SAMPLES_PER_WIN);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(RD_WIRE_CNT - 1);
  localparam logic [RND_W-1:0] LAST_RND  = RND_W'(SAMPLES_PER_WIN - 1);

  logic [31:0]                       chExt;
  logic                              chInRange;
  logic                              sampleAdd;
  logic                              roundStep;
  logic                              winEnd;
  logic                              accClr;
  logic signed [ACC_W-1:0]           xVal;
  logic [RD_WIRE_CNT-1:0][ACC_W-1:0] snap;

  logic [RND_W-1:0]                  round_q, round_d;
  emit_state_e                       state_q, state_d;
  logic [CH_W-1:0]                   outCh_q, outCh_d;
  logic [RD_WIRE_CNT-1:0][ACC_W-1:0] bank_q;
  logic                              bankLoad;
  logic                              overrun_q, overrun_d;

  // Tags beyond the last wire are ignored; compare at full width so the
  // check stays meaningful when RD_WIRE_CNT is not a power of two.
  assign chExt     = 32'(adc_ch);
  assign chInRange = chExt < 32'(RD_WIRE_CNT);
  assign sampleAdd = adc_valid && en && chInRange;
  assign roundStep = sampleAdd && (adc_ch == LAST_CH);
  assign winEnd    = roundStep && (round_q == LAST_RND);
  assign accClr    = !en || winEnd;

`ifdef TACTILE_RD_MIDSCALE_EN
  localparam logic [ACC_W-1:0] MIDSCALE = ACC_W'(1) << (ADC_W - 1);
  assign xVal = $signed(ACC_W'(adc_data) - MIDSCALE);
`else
  assign xVal = $signed(ACC_W'(adc_data));
`endif

  tactile_acc_bank #(
    .RD_WIRE_CNT (RD_WIRE_CNT),
    .ACC_W       (ACC_W),
    .CH_W        (CH_W)
  ) u_acc_bank (
    .clk_ref (clk_ref),
    .rst_n   (rst_n),
    .add_i   (sampleAdd),
    .ch_i    (adc_ch),
    .x_i     (xVal),
    .phase_i (exc_phase),
    .clr_i   (accClr),
    .snap_o  (snap)
  );

  // Round counter advances on each last-wire sample and wraps at window end.
  always_comb begin
    round_d = round_q;
    if (!en) begin
      round_d = '0;
    end else if (winEnd) begin
      round_d = '0;
    end else if (roundStep) begin
      round_d = round_q + RND_W'(1);
    end
  end

  // Emitter next state: capture a bank when idle, then walk the channels.
  always_comb begin
    state_d  = state_q;
    outCh_d  = outCh_q;
    bankLoad = 1'b0;
    unique case (state_q)
      E_IDLE: begin
        if (winEnd) begin
          state_d  = E_SHOW;
          outCh_d  = '0;
          bankLoad = 1'b1;
        end
      end
      E_SHOW: begin
        if (out_ready) begin
          if (outCh_q == LAST_CH) begin
            state_d = E_IDLE;
            outCh_d = '0;
          end else begin
            outCh_d = outCh_q + CH_W'(1);
          end
        end
      end
      default: begin
        state_d = E_IDLE;
        outCh_d = '0;
      end
    endcase
  end

  // Sticky overrun: a window ending while a bank is on show sets it; set beats clear.
  always_comb begin
    overrun_d = overrun_q;
    if (winEnd && (state_q == E_SHOW)) begin
      overrun_d = 1'b1;
    end else if (clr_ovr) begin
      overrun_d = 1'b0;
    end
  end

  // State registers for round counter, emitter, presented bank and overrun.
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      round_q   <= '0;
      state_q   <= E_IDLE;
      outCh_q   <= '0;
      bank_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      round_q   <= round_d;
      state_q   <= state_d;
      outCh_q   <= outCh_d;
      overrun_q <= overrun_d;
      if (bankLoad) begin
        bank_q <= snap;
      end
    end
  end

  assign out_valid = (state_q == E_SHOW);
  assign busy      = (state_q != E_IDLE);
  assign out_ch    = outCh_q;
  assign out_data  = bank_q[outCh_q];
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_tactile_rd_demod.sv
// Directed self-checking bench for tactile_rd_demod with two wires,
// 12-bit samples and four rounds per window.
// Scenario 6 is built only when TACTILE_RD_MIDSCALE_EN is defined.
module tb_tactile_rd_demod;

  localparam int RD    = 2;
  localparam int ADCW  = 12;
  localparam int SPW   = 4;
  localparam int ACCW  = 16;
  localparam int CHW   = 1;

  logic             clk_ref = 1'b0;
  logic             rst_n;
  logic             en;
  logic [RD-1:0]    exc_phase;
  logic             adc_valid;
  logic [CHW-1:0]   adc_ch;
  logic [ADCW-1:0]  adc_data;
  logic             out_valid;
  logic             out_ready;
  logic [CHW-1:0]   out_ch;
  logic [ACCW-1:0]  out_data;
  logic             overrun;
  logic             clr_ovr;
  logic             busy;

  int total = 0;
  int bad   = 0;

  always #5 clk_ref = ~clk_ref;

  tactile_rd_demod #(
    .RD_WIRE_CNT     (RD),
    .ADC_W           (ADCW),
    .SAMPLES_PER_WIN (SPW)
  ) dut (
    .clk_ref   (clk_ref),
    .rst_n     (rst_n),
    .en        (en),
    .exc_phase (exc_phase),
    .adc_valid (adc_valid),
    .adc_ch    (adc_ch),
    .adc_data  (adc_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr),
    .busy      (busy)
  );

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One sample, presented just after an edge and taken at the next edge.
  task automatic applyStimulus(input int ch, input int data, input logic [RD-1:0] phase);
    adc_valid = 1'b1;
    adc_ch    = CHW'(ch);
    adc_data  = ADCW'(data);
    exc_phase = phase;
    @(posedge clk_ref);
    #1;
    adc_valid = 1'b0;
  endtask

  task automatic runRound(input int data, input logic [RD-1:0] phase);
    applyStimulus(0, data, phase);
    applyStimulus(1, data, phase);
  endtask

  task automatic runWindow(input int data, input logic [RD-1:0] phase);
    for (int r = 0; r < SPW; r++) runRound(data, phase);
  endtask

  task automatic idleCycle();
    @(posedge clk_ref);
    #1;
  endtask

  // Drain both channels of a presented bank and confirm the return to idle.
  task automatic popResult(input string tag, input int exp0, input int exp1);
    checkOutput({tag, "_valid"}, 32'(out_valid), 1);
    checkOutput({tag, "_ch0"}, 32'(out_ch), 0);
    checkOutput({tag, "_data0"}, $signed(out_data), exp0);
    out_ready = 1'b1;
    idleCycle();
    checkOutput({tag, "_ch1"}, 32'(out_ch), 1);
    checkOutput({tag, "_data1"}, $signed(out_data), exp1);
    idleCycle();
    out_ready = 1'b0;
    checkOutput({tag, "_idle_valid"}, 32'(out_valid), 0);
    checkOutput({tag, "_idle_busy"}, 32'(busy), 0);
  endtask

  task automatic pulseClear();
    clr_ovr = 1'b1;
    idleCycle();
    clr_ovr = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    exc_phase = '0;
    adc_valid = 1'b0;
    adc_ch    = '0;
    adc_data  = '0;
    out_ready = 1'b0;
    clr_ovr   = 1'b0;
    #12;
    checkOutput("rst_valid", 32'(out_valid), 0);
    checkOutput("rst_data", $signed(out_data), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_ovr", 32'(overrun), 0);
    checkOutput("rst_ch", 32'(out_ch), 0);
    rst_n = 1'b1;
    en    = 1'b1;
    idleCycle();

`ifndef TACTILE_RD_MIDSCALE_EN
    $display("[TB] scenario 1: constant phase, constant data");
    for (int r = 0; r < SPW - 1; r++) runRound(100, 2'b11);
    applyStimulus(0, 100, 2'b11);
    checkOutput("s1_pre_valid", 32'(out_valid), 0);
    applyStimulus(1, 100, 2'b11);
    checkOutput("s1_busy", 32'(busy), 1);
    popResult("s1", 400, 400);

    $display("[TB] scenario 2: toggling phase");
    runRound(100, 2'b11);
    runRound(20, 2'b00);
    runRound(100, 2'b11);
    runRound(20, 2'b00);
    popResult("s2a", 160, 160);
    runRound(100, 2'b11);
    runRound(100, 2'b00);
    runRound(100, 2'b11);
    runRound(100, 2'b00);
    popResult("s2b", 0, 0);

    $display("[TB] scenario 3: overrun while stalled");
    runWindow(100, 2'b11);
    checkOutput("s3_ovr_first", 32'(overrun), 0);
    runWindow(50, 2'b11);
    checkOutput("s3_ovr_set", 32'(overrun), 1);
    checkOutput("s3_held_data", $signed(out_data), 400);
    checkOutput("s3_held_ch", 32'(out_ch), 0);
    pulseClear();
    checkOutput("s3_ovr_clr", 32'(overrun), 0);
    for (int r = 0; r < SPW - 1; r++) runRound(10, 2'b11);
    applyStimulus(0, 10, 2'b11);
    clr_ovr = 1'b1;
    applyStimulus(1, 10, 2'b11);
    clr_ovr = 1'b0;
    checkOutput("s3_set_wins", 32'(overrun), 1);
    pulseClear();
    checkOutput("s3_ovr_clr2", 32'(overrun), 0);
    popResult("s3", 400, 400);

    $display("[TB] scenario 3b: window end on the last handshake");
    runWindow(30, 2'b11);
    out_ready = 1'b1;
    idleCycle();
    out_ready = 1'b0;
    checkOutput("s3b_ch1", 32'(out_ch), 1);
    for (int r = 0; r < SPW - 1; r++) runRound(70, 2'b11);
    applyStimulus(0, 70, 2'b11);
    out_ready = 1'b1;
    applyStimulus(1, 70, 2'b11);
    out_ready = 1'b0;
    checkOutput("s3b_valid", 32'(out_valid), 0);
    checkOutput("s3b_ovr", 32'(overrun), 1);
    pulseClear();
    runWindow(25, 2'b11);
    popResult("s3b", 100, 100);

    $display("[TB] scenario 4: enable dropped mid-window");
    runRound(100, 2'b11);
    runRound(100, 2'b11);
    en = 1'b0;
    applyStimulus(0, 999, 2'b11);
    checkOutput("s4_no_valid", 32'(out_valid), 0);
    en = 1'b1;
    runWindow(50, 2'b11);
    popResult("s4", 200, 200);

    $display("[TB] scenario 5: asynchronous reset mid-show");
    runWindow(100, 2'b11);
    runWindow(100, 2'b11);
    checkOutput("s5_pre_ovr", 32'(overrun), 1);
    checkOutput("s5_pre_valid", 32'(out_valid), 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("s5_valid", 32'(out_valid), 0);
    checkOutput("s5_data", $signed(out_data), 0);
    checkOutput("s5_busy", 32'(busy), 0);
    checkOutput("s5_ovr", 32'(overrun), 0);
    @(negedge clk_ref);
    #2;
    rst_n = 1'b1;
    idleCycle();
    runWindow(100, 2'b11);
    popResult("s5", 400, 400);
`else
    $display("[TB] scenario 6: mid-scale offset removal");
    runWindow(2048, 2'b11);
    popResult("s6a", 0, 0);
    runWindow(2148, 2'b11);
    popResult("s6b", 400, 400);
    runWindow(2148, 2'b00);
    popResult("s6c", -400, -400);
    runWindow(2148, 2'b01);
    popResult("s6d", 400, -400);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
